// File: rtl/pixel_pkg.sv
// Shared pixel-memory definitions: pixel type, reader state encoding and the
// default image / display geometry used by the CPU writer, the VGA timing
// block and the display-side reader.
package pixel_pkg;

  localparam int PIX_W        = 8;
  localparam int DEF_IMG_W    = 400;
  localparam int DEF_IMG_H    = 400;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } rd_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_pixel_reader_if.sv
// Pixel-memory read port shared between the display reader (master) and the
// memory / CPU-write arbitration side (slave).
interface vga_pixel_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 18
);
  logic              cpu_wr_busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cpu_wr_busy,
    input  mem_rdata,
    output mem_rd_en,
    output mem_addr
  );

  modport slave (
    output cpu_wr_busy,
    output mem_rdata,
    input  mem_rd_en,
    input  mem_addr
  );
endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous prefetch FIFO with flush. Head is visible combinationally
// on rd_data whenever the FIFO is non-empty; push and pop in the same cycle
// are both honoured.
module pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pixel_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = store[rd_ptr];

  // Pointer and occupancy tracking; flush discards everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Data storage needs no reset; contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) store[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/vga_pixel_reader.sv
// Display-side pixel-memory reader. Prefetches an IMG_W x IMG_H image into a
// small FIFO and hands out one pixel per VGA request, background colour
// outside the image. CPU writes own the memory port whenever cpu_wr_busy is
// high. Build option UNDERFLOW_CNT_EN adds a saturating underflow counter port.
module vga_pixel_reader
  import pixel_pkg::*;
#(
  parameter int                DATA_W     = PIX_W,
  parameter int                ADDR_W     = 18,
  parameter int                IMG_W      = DEF_IMG_W,
  parameter int                IMG_H      = DEF_IMG_H,
  parameter int                H_ACTIVE   = DEF_H_ACTIVE,
  parameter int                V_ACTIVE   = DEF_V_ACTIVE,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] BG_COLOR   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 pix_req,
  vga_pixel_reader_if.master   mem,
  output logic [DATA_W-1:0]    pix_data,
  output logic                 pix_valid,
  output logic                 underflow
`ifdef UNDERFLOW_CNT_EN
  ,
  output logic [15:0]          underflow_cnt
`endif
);

  localparam int XW = cnt_w(H_ACTIVE);
  localparam int YW = cnt_w(V_ACTIVE + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] TOTAL  = ADDR_W'(IMG_W * IMG_H);
  localparam logic [XW-1:0]     X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]     Y_LIM  = YW'(V_ACTIVE);

  if (IMG_W * IMG_H >= 2 ** ADDR_W) begin : g_bad_size
    $error("vga_pixel_reader: IMG_W*IMG_H does not fit in ADDR_W bits");
  end

  rd_state_t         state;
  logic [ADDR_W-1:0] fetch_cnt;
  logic [ADDR_W-1:0] skip_cnt;
  logic [ADDR_W-1:0] skip_next;
  logic              in_flight;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [CW:0]       occupancy;

  logic              req_ok;
  logic              in_image;
  logic              under;
  logic              arrive;
  logic              discard;
  logic              issue;

  // A frame_start in the same cycle wins over the request and the arriving word.
  assign req_ok   = pix_req && !frame_start;
  assign in_image = ({1'b0, x} < (XW + 1)'(IMG_W)) && ({1'b0, y} < (YW + 1)'(IMG_H));
  assign fifo_pop = req_ok && in_image && !fifo_empty;
  assign under    = req_ok && in_image && fifo_empty;
  assign arrive   = in_flight && !frame_start;

  // A word landing in the same cycle as an underflow belongs to the skipped
  // pixel, so it is discarded immediately rather than counted for later.
  assign skip_next = skip_cnt + ADDR_W'(under);
  assign discard   = arrive && (skip_next != '0);
  assign fifo_push = arrive && !discard;

  assign occupancy = {1'b0, fifo_count} + (CW + 1)'(in_flight);
  assign issue     = ((state == FILL) || (state == STREAM)) && !frame_start &&
                     !mem.cpu_wr_busy && !fifo_full && (fetch_cnt != TOTAL) &&
                     (occupancy < (CW + 1)'(FIFO_DEPTH));

  assign mem.mem_rd_en = issue;
  assign mem.mem_addr  = fetch_cnt;

  pixel_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (frame_start),
    .wr_data (mem.mem_rdata),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Fetch FSM: sequences prefetch and tracks fetch, in-flight and skip state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fetch_cnt <= '0;
      skip_cnt  <= '0;
      in_flight <= 1'b0;
    end else if (frame_start) begin
      state     <= FILL;
      fetch_cnt <= '0;
      skip_cnt  <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= issue;
      fetch_cnt <= fetch_cnt + ADDR_W'(issue);
      skip_cnt  <= discard ? (skip_next - ADDR_W'(1)) : skip_next;
      case (state)
        IDLE:   state <= IDLE;
        FILL:   if (fifo_count == CW'(FIFO_DEPTH) || fetch_cnt == TOTAL) state <= STREAM;
        STREAM: if (fetch_cnt == TOTAL && !in_flight && fifo_empty) state <= DONE;
        DONE:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Raster position of the next request; y saturates past the last line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (frame_start) begin
      x <= '0;
      y <= '0;
    end else if (req_ok && (y != Y_LIM)) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Registered pixel response, one cycle after each accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_data  <= '0;
      pix_valid <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pix_valid <= req_ok;
      underflow <= under;
      if (fifo_pop)    pix_data <= fifo_head;
      else if (req_ok) pix_data <= BG_COLOR;
    end
  end

`ifdef UNDERFLOW_CNT_EN
  // Saturating underflow count; survives frame_start, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_cnt <= '0;
    end else if (under && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`endif

endmodule
